// File: rtl/fx_chain_sequencer_pkg.sv
// Shared types for the effect-chain sequencer: FSM encoding and fixed
// register widths used by the top level and its SRAM owner mux.
package fx_chain_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_OUTPUT = 3'd4
  } state_t;

  localparam int IDX_W   = 4;
  localparam int TIMER_W = 8;

endpackage

// File: rtl/fx_sram_mux.sv
// Combinational owner-select for the single smart_ram read port; requests
// from slots that do not hold the turn are dropped.
module fx_sram_mux
  import fx_chain_sequencer_pkg::*;
#(
  parameter int NUM_FX     = 4,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                         owner_valid,
  input  logic [IDX_W-1:0]             owner,
  input  logic [NUM_FX-1:0]            fx_sram_rd,
  input  logic [NUM_FX*ADDR_WIDTH-1:0] fx_sram_offset,
  output logic [NUM_FX-1:0]            fx_sram_read_finish,
  output logic                         sram_rd,
  output logic [ADDR_WIDTH-1:0]        sram_offset,
  input  logic                         sram_read_finish
);

  always_comb begin
    sram_rd             = 1'b0;
    sram_offset         = '0;
    fx_sram_read_finish = '0;
    for (int k = 0; k < NUM_FX; k++) begin
      if (owner_valid && owner == IDX_W'(k)) begin
        sram_rd                = fx_sram_rd[k];
        sram_offset            = fx_sram_offset[k*ADDR_WIDTH +: ADDR_WIDTH];
        fx_sram_read_finish[k] = sram_read_finish;
      end
    end
  end

endmodule

// File: rtl/fx_chain_sequencer.sv
// Per-sample scheduler: walks one audio sample through the enabled effect
// slots in order, lending the smart_ram port to the slot holding the turn.
module fx_chain_sequencer
  import fx_chain_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int NUM_FX     = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_valid,
  input  logic [DATA_WIDTH-1:0]        sample_in,
  input  logic [NUM_FX-1:0]            fx_enable,
  output logic [NUM_FX-1:0]            fx_cs,
  output logic [NUM_FX-1:0]            fx_turn,
  output logic [DATA_WIDTH-1:0]        fx_data_in,
  input  logic [NUM_FX-1:0]            fx_done,
  input  logic [NUM_FX*DATA_WIDTH-1:0] fx_data_out,
  input  logic [NUM_FX-1:0]            fx_sram_rd,
  input  logic [NUM_FX*ADDR_WIDTH-1:0] fx_sram_offset,
  output logic [NUM_FX-1:0]            fx_sram_read_finish,
  output logic                         sram_rd,
  output logic [ADDR_WIDTH-1:0]        sram_offset,
  input  logic                         sram_read_finish,
  output logic [DATA_WIDTH-1:0]        sample_out,
  output logic                         sample_out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam logic [IDX_W-1:0]   IDX_END   = IDX_W'(NUM_FX);
  localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(TIMEOUT);
  localparam logic [NUM_FX-1:0]  SLOT_ONE  = NUM_FX'(1);

  state_t                        state, state_n;
  logic [IDX_W-1:0]              idx, idx_n;
  logic signed [DATA_WIDTH-1:0]  chain, chain_n;
  logic [NUM_FX-1:0]             en_lat, en_lat_n;
  logic [TIMER_W-1:0]            timer, timer_n;
  logic [NUM_FX-1:0]             sel;
  logic signed [DATA_WIDTH-1:0]  slot_data;

  // sel is empty once idx reaches NUM_FX, so no slot can match there
  assign sel = SLOT_ONE << idx;

  always_comb begin
    slot_data = '0;
    for (int k = 0; k < NUM_FX; k++) begin
      if (idx == IDX_W'(k)) slot_data = fx_data_out[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      chain   <= '0;
      en_lat  <= '0;
      timer   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      chain   <= chain_n;
      en_lat  <= en_lat_n;
      timer   <= timer_n;
      overrun <= sample_valid && (state != ST_IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    chain_n     = chain;
    en_lat_n    = en_lat;
    timer_n     = timer;
    timeout_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_valid) begin
          chain_n  = sample_in;
          idx_n    = '0;
          en_lat_n = fx_enable;
          state_n  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx == IDX_END)          state_n = ST_OUTPUT;
        else if (|(en_lat & sel))    state_n = ST_ISSUE;
        else                         idx_n   = idx + 1'b1;
      end
      ST_ISSUE: begin
        timer_n = '0;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        // done from any other slot (e.g. one already abandoned) is ignored
        if (|(fx_done & sel)) begin
          chain_n = slot_data;
          idx_n   = idx + 1'b1;
          state_n = ST_SCAN;
        end else if (timer == TIMER_END) begin
          timeout_err = 1'b1;
          idx_n       = idx + 1'b1;
          state_n     = ST_SCAN;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_OUTPUT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign fx_turn          = (state == ST_ISSUE) ? sel : '0;
  assign fx_cs            = en_lat;
  assign fx_data_in       = chain;
  assign busy             = (state != ST_IDLE);
  assign sample_out_valid = (state == ST_OUTPUT);
  assign sample_out       = (state == ST_OUTPUT) ? chain : '0;

  fx_sram_mux #(
    .NUM_FX     (NUM_FX),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram_mux (
    .owner_valid         ((state == ST_ISSUE) || (state == ST_WAIT)),
    .owner               (idx),
    .fx_sram_rd          (fx_sram_rd),
    .fx_sram_offset      (fx_sram_offset),
    .fx_sram_read_finish (fx_sram_read_finish),
    .sram_rd             (sram_rd),
    .sram_offset         (sram_offset),
    .sram_read_finish    (sram_read_finish)
  );

endmodule

// File: tb/tb_fx_chain_sequencer.sv
// Directed bench for fx_chain_sequencer with behavioural effect-slot stubs.
module tb_fx_chain_sequencer;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int NF = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           sample_valid;
  logic [DW-1:0]  sample_in;
  logic [NF-1:0]  fx_enable;
  logic [NF-1:0]  fx_cs;
  logic [NF-1:0]  fx_turn;
  logic [DW-1:0]  fx_data_in;
  logic [NF-1:0]  fx_done;
  logic [NF*DW-1:0] fx_data_out;
  logic [NF-1:0]  fx_sram_rd;
  logic [NF*AW-1:0] fx_sram_offset;
  logic [NF-1:0]  fx_sram_read_finish;
  logic           sram_rd;
  logic [AW-1:0]  sram_offset;
  logic           sram_read_finish;
  logic [DW-1:0]  sample_out;
  logic           sample_out_valid;
  logic           busy;
  logic           overrun;
  logic           timeout_err;

  fx_chain_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FX(NF), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .fx_enable(fx_enable), .fx_cs(fx_cs), .fx_turn(fx_turn),
    .fx_data_in(fx_data_in), .fx_done(fx_done), .fx_data_out(fx_data_out),
    .fx_sram_rd(fx_sram_rd), .fx_sram_offset(fx_sram_offset),
    .fx_sram_read_finish(fx_sram_read_finish), .sram_rd(sram_rd),
    .sram_offset(sram_offset), .sram_read_finish(sram_read_finish),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slot stubs: op 0 -> in+1, op 1 -> in*2, op 2 -> never done.
  // done comes D cycles after the ISSUE edge (inclusive).
  int          op   [NF];
  int          dly  [NF];
  logic [NF-1:0] force_done;
  logic [DW-1:0] cap [NF];
  int          cnt  [NF];
  bit          sbusy[NF];
  logic [NF-1:0] stub_done;

  always @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (fx_turn[k]) begin
        cap[k]   <= fx_data_in;
        cnt[k]   <= 1;
        sbusy[k] <= 1'b1;
      end else if (sbusy[k]) begin
        if (cnt[k] >= dly[k]) sbusy[k] <= 1'b0;
        else                  cnt[k]   <= cnt[k] + 1;
      end
    end
  end

  always_comb begin
    stub_done   = '0;
    fx_data_out = '0;
    for (int k = 0; k < NF; k++) begin
      stub_done[k] = sbusy[k] && (cnt[k] == dly[k]) && (op[k] != 2);
      if (force_done[k])  fx_data_out[k*DW +: DW] = 16'hDEAD;
      else if (op[k] == 1) fx_data_out[k*DW +: DW] = cap[k] << 1;
      else                 fx_data_out[k*DW +: DW] = cap[k] + 16'd1;
    end
  end

  assign fx_done = stub_done | force_done;

  // Event monitors sampled on the falling edge
  int          valid_cnt = 0;
  int          ovr_cnt   = 0;
  int          to_cnt    = 0;
  logic [NF-1:0] turn_log[$];

  always @(negedge clk) begin
    if (sample_out_valid) valid_cnt++;
    if (overrun)          ovr_cnt++;
    if (timeout_err)      to_cnt++;
    if (fx_turn != '0)    turn_log.push_back(fx_turn);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sample(input logic [DW-1:0] v, input logic [NF-1:0] en);
    sample_valid = 1'b1;
    sample_in    = v;
    fx_enable    = en;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_out_valid && n < 400);
    if (!sample_out_valid) n = -1;
  endtask

  initial begin
    int n, t0, v0, o0, c0;
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0; fx_enable = '0;
    fx_sram_rd = '0; fx_sram_offset = '0; sram_read_finish = 1'b0;
    force_done = '0;
    for (int k = 0; k < NF; k++) begin op[k] = 0; dly[k] = 3; end
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", 32'({fx_cs, fx_turn, fx_sram_read_finish, sram_rd, sample_out_valid,
                         overrun, timeout_err}), 0);
    chk("rst_sram_offset", 32'(sram_offset), 0);
    chk("rst_sample_out", 32'(sample_out), 0);
    fx_sram_rd = 4'b1111;
    fx_sram_offset = {4{13'h0ABC}};
    #1;
    chk("idle_no_owner_rd", 32'(sram_rd), 0);
    chk("idle_no_owner_off", 32'(sram_offset), 0);
    fx_sram_rd = '0;

    // All slots disabled: passthrough, OUTPUT in cycle 6
    t0 = turn_log.size();
    start_sample(16'h1234, 4'b0000);
    wait_valid(n);
    chk("bypass_latency", 32'(n), 5);
    chk("bypass_value", 32'(sample_out), 32'h1234);
    tick();
    chk("bypass_idle", 32'(busy), 0);
    chk("bypass_no_turn", 32'(turn_log.size() - t0), 0);

    // Slots 0 (+1) and 2 (*2), D=3
    op[0] = 0; dly[0] = 3; op[2] = 1; dly[2] = 3;
    t0 = turn_log.size();
    start_sample(16'h0100, 4'b0101);
    chk("chain_cs", 32'(fx_cs), 32'h5);
    chk("chain_data_in", 32'(fx_data_in), 32'h0100);
    wait_valid(n);
    chk("chain_latency", 32'(n), 13);
    chk("chain_value", 32'(sample_out), 32'h0202);
    chk("chain_turn_count", 32'(turn_log.size() - t0), 2);
    chk("chain_turn0", 32'(turn_log[t0]), 32'h1);
    chk("chain_turn1", 32'(turn_log[t0+1]), 32'h4);
    tick();

    // SRAM ownership: slot 1 holds the port in WAIT
    op[1] = 0; dly[1] = 60;
    fx_sram_offset = '0;
    fx_sram_offset[1*AW +: AW] = 13'h02D0;
    fx_sram_offset[3*AW +: AW] = 13'h1FFF;
    start_sample(16'h0055, 4'b0010);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      fx_sram_rd = 4'b0010;
      #1;
      chk("sram_rd_owner", 32'(sram_rd), 1);
      chk("sram_offset_owner", 32'(sram_offset), 32'h02D0);
      sram_read_finish = 1'b1;
      #1;
      chk("sram_finish_routed", 32'(fx_sram_read_finish), 32'h2);
      tick();
      sram_read_finish = 1'b0;
      fx_sram_rd = '0;
      #1;
      chk("sram_finish_clear", 32'(fx_sram_read_finish), 0);
    end
    fx_sram_rd = 4'b1000;
    sram_read_finish = 1'b1;
    #1;
    chk("sram_nonowner_rd", 32'(sram_rd), 0);
    chk("sram_nonowner_off", 32'(sram_offset), 32'h02D0);
    chk("sram_nonowner_finish", 32'(fx_sram_read_finish), 32'h2);
    fx_sram_rd = '0;
    sram_read_finish = 1'b0;
    wait_valid(n);
    chk("sram_latency", 32'(n), 60);
    chk("sram_value", 32'(sample_out), 32'h0056);
    tick();

    // Slot 0 hangs, slot 1 adds one
    op[0] = 2; dly[0] = 5; op[1] = 0; dly[1] = 3;
    c0 = to_cnt;
    start_sample(16'h0777, 4'b0011);
    repeat (256) tick();
    chk("timeout_early", 32'(timeout_err), 0);
    tick();
    chk("timeout_pulse", 32'(timeout_err), 1);
    tick();
    chk("timeout_single", 32'(timeout_err), 0);
    wait_valid(n);
    chk("timeout_latency", 32'(n), 8);
    chk("timeout_value", 32'(sample_out), 32'h0778);
    chk("timeout_count", 32'(to_cnt - c0), 1);
    repeat (35) tick();
    v0 = valid_cnt;
    force_done = 4'b0001;
    #1;
    chk("late_done_idle", 32'(busy), 0);
    tick();
    force_done = '0;
    chk("late_done_ignored", 32'({busy, sample_out_valid}), 0);
    chk("late_done_no_valid", 32'(valid_cnt - v0), 0);

    // Overrun: second sample 5 cycles later is dropped
    op[0] = 0; dly[0] = 20;
    v0 = valid_cnt; o0 = ovr_cnt;
    start_sample(16'h0010, 4'b0001);
    repeat (4) tick();
    sample_valid = 1'b1; sample_in = 16'h7777;
    tick();
    sample_valid = 1'b0;
    chk("overrun_pulse", 32'(overrun), 1);
    tick();
    chk("overrun_single", 32'(overrun), 0);
    wait_valid(n);
    chk("overrun_latency", 32'(n), 20);
    chk("overrun_value", 32'(sample_out), 32'h0011);
    repeat (10) tick();
    chk("overrun_valid_count", 32'(valid_cnt - v0), 1);
    chk("overrun_count", 32'(ovr_cnt - o0), 1);

    // Reset while a slot is in WAIT
    dly[0] = 10;
    start_sample(16'h0AAA, 4'b0001);
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_outs", 32'({fx_cs, fx_turn, fx_sram_read_finish, sram_rd, sample_out_valid,
                             overrun, timeout_err}), 0);
    chk("mid_rst_data", 32'({sample_out, fx_data_in}), 0);
    repeat (10) tick();
    chk("rst_stale_done_ignored", 32'(busy), 0);
    dly[0] = 3;
    start_sample(16'h0100, 4'b0001);
    wait_valid(n);
    chk("post_rst_latency", 32'(n), 9);
    chk("post_rst_value", 32'(sample_out), 32'h0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
